// File: rtl/brick_health_tracker.sv
// Brick touch bitmap, per-life health and invulnerability window for the game-state arbiter.
// Optional bonus-life feature enabled by defining BONUS_LIFE_EN.
module brick_health_tracker #(
    parameter int NUM_BRICKS    = 50,
    parameter int INIT_HEALTH   = 3,
    parameter int INVULN_CYCLES = 16,
    parameter int BONUS_EVERY   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            game_state,
    input  logic                  hit_valid,
    input  logic [5:0]            hit_index,
    input  logic                  dmg_valid,
    output logic [NUM_BRICKS-1:0] bk_touched,
    output logic [3:0]            health,
    output logic [5:0]            touched_cnt,
    output logic                  new_touch,
    output logic                  invuln,
    output logic                  bonus_pulse
);

    localparam int CW = $clog2(INVULN_CYCLES + 1);

    localparam logic [1:0] GS_BEGIN   = 2'b00;
    localparam logic [1:0] GS_PLAYING = 2'b01;

    typedef enum logic [1:0] {
        ST_ARM    = 2'b00,
        ST_PLAY   = 2'b01,
        ST_INVULN = 2'b10,
        ST_FROZEN = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_BRICKS-1:0]   bk_touched_q, bk_touched_d;
    logic [3:0]              health_q, health_d;
    logic [5:0]              touched_cnt_q, touched_cnt_d;
    logic                    new_touch_q, new_touch_d;
    logic                    invuln_q, invuln_d;
    logic [CW-1:0]           timer_q, timer_d;

    logic [NUM_BRICKS-1:0]   hit_set;
    logic                    hit_new;
    logic                    upd;
    logic                    dmg_take;
    logic                    bonus_take;

    // One-hot of the brick that would flip from clear to set this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BRICKS; gi++) begin : g_hit
            assign hit_set[gi] = hit_valid && (hit_index == 6'(gi)) && !bk_touched_q[gi];
        end
    endgenerate

    assign hit_new = |hit_set;
    assign upd     = ((state_q == ST_PLAY) || (state_q == ST_INVULN)) && (game_state == GS_PLAYING);

`ifdef BONUS_LIFE_EN
    localparam int BW = $clog2(BONUS_EVERY + 1);

    logic [BW-1:0] bonus_cnt_q, bonus_cnt_d;
    logic          bonus_q, bonus_d;

    // Counts new touches modulo BONUS_EVERY; wraps exactly when touched_cnt hits a multiple.
    always_comb begin
        bonus_cnt_d = bonus_cnt_q;
        bonus_d     = 1'b0;
        if (game_state == GS_BEGIN) begin
            bonus_cnt_d = '0;
        end else if (upd && hit_new) begin
            if (bonus_cnt_q == BW'(BONUS_EVERY - 1)) begin
                bonus_cnt_d = '0;
                bonus_d     = 1'b1;
            end else begin
                bonus_cnt_d = bonus_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bonus_cnt_q <= '0;
            bonus_q     <= 1'b0;
        end else begin
            bonus_cnt_q <= bonus_cnt_d;
            bonus_q     <= bonus_d;
        end
    end

    assign bonus_take  = bonus_d;
    assign bonus_pulse = bonus_q;
`else
    // The bonus interval is meaningful only with the bonus feature built in.
    if (BONUS_EVERY < 1) begin : g_bonus_every_invalid
    end

    assign bonus_take  = 1'b0;
    assign bonus_pulse = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bk_touched_d  = bk_touched_q;
        health_d      = health_q;
        touched_cnt_d = touched_cnt_q;
        new_touch_d   = 1'b0;
        invuln_d      = invuln_q;
        timer_d       = timer_q;
        dmg_take      = 1'b0;

        if (game_state == GS_BEGIN) begin
            state_d       = ST_ARM;
            bk_touched_d  = '0;
            health_d      = 4'(INIT_HEALTH);
            touched_cnt_d = '0;
            invuln_d      = 1'b0;
            timer_d       = '0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (game_state == GS_PLAYING) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY, ST_INVULN: begin
                    if (!upd) begin
                        state_d = ST_FROZEN;
                    end else begin
                        if (state_q == ST_INVULN) begin
                            timer_d = timer_q - 1'b1;
                            if (timer_q == CW'(1)) begin
                                state_d  = ST_PLAY;
                                invuln_d = 1'b0;
                            end
                        end else if (dmg_valid) begin
                            dmg_take = 1'b1;
                            timer_d  = CW'(INVULN_CYCLES);
                            state_d  = ST_INVULN;
                            invuln_d = 1'b1;
                        end

                        if (hit_new) begin
                            bk_touched_d  = bk_touched_q | hit_set;
                            touched_cnt_d = touched_cnt_q + 6'd1;
                            new_touch_d   = 1'b1;
                        end

                        // Damage and bonus in one cycle cancel; each saturates alone.
                        if (dmg_take && !bonus_take && (health_q != 4'd0)) begin
                            health_d = health_q - 4'd1;
                        end else if (bonus_take && !dmg_take && (health_q != 4'd15)) begin
                            health_d = health_q + 4'd1;
                        end

                        if ((health_d == 4'd0) || (touched_cnt_d == 6'(NUM_BRICKS))) begin
                            state_d = ST_FROZEN;
                        end
                    end
                end
                default: begin
                    state_d = ST_FROZEN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_ARM;
            bk_touched_q  <= '0;
            health_q      <= 4'(INIT_HEALTH);
            touched_cnt_q <= '0;
            new_touch_q   <= 1'b0;
            invuln_q      <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            bk_touched_q  <= bk_touched_d;
            health_q      <= health_d;
            touched_cnt_q <= touched_cnt_d;
            new_touch_q   <= new_touch_d;
            invuln_q      <= invuln_d;
            timer_q       <= timer_d;
        end
    end

    assign bk_touched  = bk_touched_q;
    assign health      = health_q;
    assign touched_cnt = touched_cnt_q;
    assign new_touch   = new_touch_q;
    assign invuln      = invuln_q;

endmodule

// File: tb/tb_brick_health_tracker.sv
// Self-checking bench for brick_health_tracker: directed scenarios plus randomized play
// compared against an event-level reference model.
module tb_brick_health_tracker;

    localparam int NB = 50;
    localparam int IH = 3;
    localparam int IC = 16;
    localparam int BE = 10;

    localparam int PH_ARM    = 0;
    localparam int PH_LIVE   = 1;
    localparam int PH_FROZEN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  game_state;
    logic        hit_valid;
    logic [5:0]  hit_index;
    logic        dmg_valid;
    logic [49:0] bk_touched;
    logic [3:0]  health;
    logic [5:0]  touched_cnt;
    logic        new_touch;
    logic        invuln;
    logic        bonus_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit [49:0] m_bk;
    int        m_health;
    int        m_cnt;
    int        m_window;
    int        m_phase;
    bit        m_new;
    bit        m_bonus;
    bit        m_invuln;

    int        inv_cycles;
    int        perm [NB];
    int        full_health;

    brick_health_tracker #(
        .NUM_BRICKS   (NB),
        .INIT_HEALTH  (IH),
        .INVULN_CYCLES(IC),
        .BONUS_EVERY  (BE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .game_state (game_state),
        .hit_valid  (hit_valid),
        .hit_index  (hit_index),
        .dmg_valid  (dmg_valid),
        .bk_touched (bk_touched),
        .health     (health),
        .touched_cnt(touched_cnt),
        .new_touch  (new_touch),
        .invuln     (invuln),
        .bonus_pulse(bonus_pulse)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        m_bk     = '0;
        m_health = IH;
        m_cnt    = 0;
        m_window = 0;
        m_phase  = PH_ARM;
        m_new    = 1'b0;
        m_bonus  = 1'b0;
        m_invuln = 1'b0;
    endfunction

    // Applies one sampled clock edge of the game rules to the model.
    function automatic void m_step(input logic [1:0] gs, input bit hv, input int hi, input bit dv);
        bit fresh;
        bit took;
        int delta;
        m_new   = 1'b0;
        m_bonus = 1'b0;
        if (gs == 2'b00) begin
            m_reset();
        end else if (m_phase == PH_ARM) begin
            if (gs == 2'b01) m_phase = PH_LIVE;
        end else if (m_phase == PH_LIVE) begin
            if (gs != 2'b01) begin
                m_phase = PH_FROZEN;
            end else begin
                fresh = hv && (hi < NB) && !m_bk[hi];
                took  = dv && (m_window == 0);
                if (m_window > 0) m_window--;
                if (took) m_window = IC;
                delta = 0;
                if (fresh) begin
                    m_bk[hi] = 1'b1;
                    m_cnt++;
                    m_new = 1'b1;
`ifdef BONUS_LIFE_EN
                    if (m_cnt % BE == 0) begin
                        m_bonus = 1'b1;
                        delta++;
                    end
`endif
                end
                if (took) delta--;
                m_health += delta;
                if (m_health < 0) m_health = 0;
                if (m_health > 15) m_health = 15;
                m_invuln = (m_window > 0);
                if ((m_health == 0) || (m_cnt == NB)) m_phase = PH_FROZEN;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("bk_touched", 64'(bk_touched), 64'(m_bk));
        chk("health", 64'(health), 64'(m_health));
        chk("touched_cnt", 64'(touched_cnt), 64'(m_cnt));
        chk("new_touch", 64'(new_touch), 64'(m_new));
        chk("bonus_pulse", 64'(bonus_pulse), 64'(m_bonus));
        if (m_phase != PH_FROZEN) chk("invuln", 64'(invuln), 64'(m_invuln));
    endtask

    task automatic cycle(input logic [1:0] gs, input bit hv, input int hi, input bit dv);
        @(negedge clk);
        game_state = gs;
        hit_valid  = hv;
        hit_index  = 6'(hi);
        dmg_valid  = dv;
        @(posedge clk);
        m_step(gs, hv, hi, dv);
        #1;
        compare_all();
        $display("t=%0t gs=%b hit=%0b/%0d dmg=%0b -> health=%0d cnt=%0d new=%0b inv=%0b bonus=%0b",
                 $time, gs, hv, hi, dv, health, touched_cnt, new_touch, invuln, bonus_pulse);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        game_state = 2'b00;
        hit_valid  = 1'b0;
        hit_index  = 6'd0;
        dmg_valid  = 1'b0;
        m_reset();
        full_health = IH;
`ifdef BONUS_LIFE_EN
        full_health = IH + NB / BE;
        if (full_health > 15) full_health = 15;
`endif

        // Reset state
        #12;
        compare_all();
        chk("reset_health", 64'(health), 64'(IH));
        reset = 1'b1;

        // Basic touches: 0, 0 (repeat), 49, 55 (out of range)
        cycle(2'b00, 0, 0, 0);
        cycle(2'b01, 0, 0, 0);
        cycle(2'b01, 1, 0, 0);
        chk("first_touch_pulse", 64'(new_touch), 64'd1);
        cycle(2'b01, 1, 0, 0);
        chk("repeat_no_pulse", 64'(new_touch), 64'd0);
        cycle(2'b01, 1, 49, 0);
        chk("touch49_pulse", 64'(new_touch), 64'd1);
        cycle(2'b01, 1, 55, 0);
        chk("oob_no_pulse", 64'(new_touch), 64'd0);
        chk("bitmap_two", 64'(bk_touched), (64'd1 << 49) | 64'd1);
        chk("cnt_two", 64'(touched_cnt), 64'd2);

        // Damage with invulnerability window
        inv_cycles = 0;
        cycle(2'b01, 0, 0, 1);
        inv_cycles += int'(invuln);
        chk("dmg1_health", 64'(health), 64'd2);
        for (int k = 0; k < 4; k++) begin
            cycle(2'b01, 0, 0, 0);
            inv_cycles += int'(invuln);
        end
        cycle(2'b01, 0, 0, 1);
        inv_cycles += int'(invuln);
        chk("dmg2_ignored", 64'(health), 64'd2);
        for (int k = 0; k < 40 && invuln; k++) begin
            cycle(2'b01, 0, 0, 0);
            inv_cycles += int'(invuln);
        end
        chk("invuln_len", 64'(inv_cycles), 64'(IC));
        chk("invuln_closed", 64'(invuln), 64'd0);
        cycle(2'b01, 0, 0, 1);
        chk("dmg3_health", 64'(health), 64'd1);
        chk("dmg3_invuln", 64'(invuln), 64'd1);
        for (int k = 0; k < 40 && invuln; k++) cycle(2'b01, 0, 0, 0);
        chk("window2_closed", 64'(invuln), 64'd0);

        // Health to zero freezes; later hits ignored; re-arm restores
        cycle(2'b01, 0, 0, 1);
        chk("health_zero", 64'(health), 64'd0);
        cycle(2'b01, 1, 7, 0);
        cycle(2'b01, 1, 8, 0);
        chk("frozen_bitmap", 64'(bk_touched), (64'd1 << 49) | 64'd1);
        chk("frozen_no_pulse", 64'(new_touch), 64'd0);
        cycle(2'b00, 0, 0, 0);
        chk("rearm_health", 64'(health), 64'(IH));
        chk("rearm_bitmap", 64'(bk_touched), 64'd0);

        // Touch all bricks in shuffled order, one per cycle
        for (int i = 0; i < NB; i++) perm[i] = i;
        for (int i = NB - 1; i > 0; i--) begin
            int j;
            int t;
            j       = int'($urandom_range(0, i));
            t       = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        cycle(2'b01, 0, 0, 0);
        for (int i = 0; i < NB; i++) cycle(2'b01, 1, perm[i], 0);
        chk("full_cnt", 64'(touched_cnt), 64'(NB));
        chk("full_last_pulse", 64'(new_touch), 64'd1);
        chk("full_health", 64'(health), 64'(full_health));
        cycle(2'b01, 1, 3, 1);
        chk("full_frozen_health", 64'(health), 64'(full_health));
        chk("full_frozen_pulse", 64'(new_touch), 64'd0);

`ifdef BONUS_LIFE_EN
        // Tenth new touch together with damage: net health change zero
        cycle(2'b00, 0, 0, 0);
        cycle(2'b01, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(2'b01, 1, i, 0);
        cycle(2'b01, 1, 9, 1);
        chk("bonus_dmg_health", 64'(health), 64'(IH));
        chk("bonus_dmg_pulse", 64'(bonus_pulse), 64'd1);
        chk("bonus_dmg_invuln", 64'(invuln), 64'd1);
`endif

        // Randomized games
        for (int g = 0; g < 6; g++) begin
            cycle(2'b00, 0, 0, 0);
            cycle(2'b01, 0, 0, 0);
            for (int k = 0; k < 150; k++) begin
                logic [1:0] gs;
                int         r;
                bit         hv;
                int         hi;
                bit         dv;
                r  = int'($urandom_range(0, 299));
                gs = 2'b01;
                if (r == 0) gs = 2'b00;
                else if (r == 1) gs = 2'b10;
                else if (r == 2) gs = 2'b11;
                hv = ($urandom_range(0, 99) < 60);
                hi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(50, 63))
                                                 : int'($urandom_range(0, 49));
                dv = ($urandom_range(0, 99) < 6);
                cycle(gs, hv, hi, dv);
            end
        end

        // Asynchronous reset in the middle of the invulnerability window
        cycle(2'b00, 0, 0, 0);
        cycle(2'b01, 0, 0, 0);
        cycle(2'b01, 1, 4, 0);
        cycle(2'b01, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(2'b01, 0, 0, 0);
        chk("pre_reset_invuln", 64'(invuln), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        m_reset();
        compare_all();
        chk("async_invuln", 64'(invuln), 64'd0);
        chk("async_health", 64'(health), 64'(IH));
        #2;
        reset = 1'b1;
        cycle(2'b00, 0, 0, 0);
        cycle(2'b01, 0, 0, 0);
        cycle(2'b01, 1, 12, 0);
        chk("post_reset_touch", 64'(touched_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/brick_health_tracker.md
# brick_health_tracker

Producer of the `bk_touched` vector and `health` count consumed by the game-state arbiter. Accepts per-brick touch events and player-damage events from the collision logic, keeps the 50-bit touched bitmap, per-life health with a post-damage invulnerability window, and a touched-brick counter. Watches `game_state` so that it re-arms on begin (`00`), updates only while playing (`01`), and freezes on win (`11`) or lose (`10`).

## Interface
- `NUM_BRICKS`, 50, width of the touched bitmap; `hit_index` values at or above this are ignored.
- `INIT_HEALTH`, 3, health loaded on reset and on re-arm; must be 1..15.
- `INVULN_CYCLES`, 16, cycles after a damage hit during which further damage is ignored; must be ≥1.
- `BONUS_EVERY`, 10, newly touched bricks per bonus life; used only when `BONUS_LIFE_EN` is defined.

- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `game_state` in 2: `00` begin, `01` playing, `11` win, `10` lose.
- `hit_valid` in 1: touch event qualifier, one event per cycle.
- `hit_index` in 6: brick index of the touch event.
- `dmg_valid` in 1: player-damage event, single-cycle pulse.
- `bk_touched` out 50: bit i set once brick i has been touched.
- `health` out 4: remaining health.
- `touched_cnt` out 6: population count of `bk_touched`, 0..50.
- `new_touch` out 1: one-cycle pulse when a previously clear bit is set.
- `invuln` out 1: high while in the invulnerability window.
- `bonus_pulse` out 1: one-cycle pulse when a bonus life is granted.

## Operation
- FSM states: ARM, PLAY, INVULN, FROZEN. Reset (`reset`=0) enters ARM asynchronously: `bk_touched`=0, `health`=`INIT_HEALTH`, `touched_cnt`=0, `new_touch`=0, `invuln`=0, `bonus_pulse`=0, invulnerability counter=0.
- Any state, `game_state`=`00`: go to ARM and reload all reset values at the next edge. This takes priority over every event.
- ARM: with `game_state`=`01`, go to PLAY. Events are ignored in ARM.
- PLAY and INVULN: on `hit_valid` with `hit_index` < `NUM_BRICKS` and that bit clear, set the bit, increment `touched_cnt`, and pulse `new_touch`. A repeat hit on a set bit or an out-of-range index changes nothing and gives no pulse.
- PLAY: `dmg_valid` decrements `health` (saturating at 0), loads the counter with `INVULN_CYCLES`, and moves to INVULN (`invuln`=1).
- INVULN: `dmg_valid` is ignored. The counter decrements each cycle, and the block returns to PLAY on the edge where the counter reaches 0. Hits are still processed.
- Hit and damage in the same cycle are both applied.
- Move to FROZEN on the edge where `health` becomes 0 or `touched_cnt` becomes `NUM_BRICKS`. FROZEN holds all outputs and ignores events. `game_state` of `11`/`10` while in PLAY or INVULN also forces FROZEN.
- `health` never wraps below 0 or above 15.

## Timing
- Event to output latency is one cycle: bitmap, count, health, and pulses are registered on the edge that samples the event.
- `invuln` rises on the same edge as the health decrement and stays high for exactly `INVULN_CYCLES` cycles.
- The arbiter sees `health`=0 or a full bitmap one cycle after the causing event, and its `game_state` follows one cycle later. The tracker is already FROZEN by then.
- Asserting `reset` mid-game clears everything immediately, with no clock needed. Deassertion is expected to be synchronised externally.

## Configuration
- `BONUS_LIFE_EN` defined: each time `touched_cnt` increments to a nonzero multiple of `BONUS_EVERY`, `health` increments (saturating at 15) and `bonus_pulse` fires for one cycle. If damage lands in the same cycle, the net health change is 0 and both the damage and the bonus are reported: `invuln` rises and `bonus_pulse` fires. If this cycle also completes the bitmap, the block goes to FROZEN regardless of health.
- `BONUS_LIFE_EN` undefined: no bonus logic; `bonus_pulse` is tied to 0.

## Test plan
- Reset, then `game_state`=`01`, hits at indices 0, 0, 49, 55 → `bk_touched`=bit0|bit49, `touched_cnt`=2, `new_touch` pulses twice, and index 55 and the repeat are ignored.
- Two `dmg_valid` pulses 5 cycles apart with `INVULN_CYCLES`=16 → `health` 3→2 only, `invuln` high 16 cycles. A third pulse after the window → `health`=1.
- Damage until `health`=0 → FROZEN, and subsequent hits leave `bk_touched` unchanged. Then `game_state`=`00` → next edge `health`=3, bitmap 0.
- Touch all 50 bricks with one hit per cycle → `touched_cnt`=50 and FROZEN on the 50th edge; `health` unchanged without `BONUS_LIFE_EN`.
- With `BONUS_LIFE_EN`, 10th new hit coinciding with `dmg_valid` → `health` unchanged at 3, `bonus_pulse`=1, `invuln`=1.
- Drop `reset` to 0 mid-INVULN, between clock edges → all outputs return to reset values immediately.
